// File: rtl/clk_gate_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_gate_ctrl_pkg : shared state encoding and sizing helper               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SLEEP_REQ = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } clk_gate_state_e;

  // Width needed to hold the larger of the two cycle budgets.
  function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
    int max_v;
    max_v = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gate_ctrl_tc_clk_gating.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tc_clk_gating : latch-based clock gate with scan-enable bypass            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tc_clk_gating #(
  parameter bit IS_FUNCTIONAL = 1'b1
) (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  generate
    if (IS_FUNCTIONAL) begin : g_functional
      logic r_en_latched;

      // Transparent while the clock is low so the enable can never chop a high phase.
      always_latch begin
        if (!clk_i) begin
          r_en_latched <= en_i | test_en_i;
        end
      end

      assign clk_o = clk_i & r_en_latched;
    end else begin : g_passthru
      logic w_unused;
      assign w_unused = en_i ^ test_en_i;
      assign clk_o    = clk_i;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_gate_ctrl : idle-driven clock gate controller with sleep/wake handshake |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2,
  parameter int CntWidth   = cnt_width(IdleCycles, WakeCycles)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       test_en_i,
  input  logic       auto_en_i,
  input  logic       busy_i,
  input  logic       wake_req_i,
  input  logic       sleep_ack_i,
  output logic       sleep_req_o,
  output logic       wake_ack_o,
  output logic       clk_en_o,
  output logic       gated_o,
  output logic [1:0] state_o,
  output logic       clk_o
);

  localparam logic [CntWidth-1:0] c_idle_last = CntWidth'(IdleCycles - 1);
  localparam logic [CntWidth-1:0] c_wake_last = CntWidth'(WakeCycles - 1);
  localparam logic [CntWidth-1:0] c_cnt_max   = {CntWidth{1'b1}};

  clk_gate_state_e     r_state;
  clk_gate_state_e     w_state_next;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_next;
  logic [CntWidth-1:0] w_cnt_inc;
  logic                r_wake_by_req;
  logic                w_wake_by_req_next;
  logic                w_wake_ack_next;
  logic                w_wake;

  assign w_wake    = wake_req_i | busy_i;
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_wake_ack_next    = 1'b0;
    w_wake_by_req_next = r_wake_by_req;
    case (r_state)
      RUN: begin
        w_wake_ack_next = wake_req_i;
        if (w_wake || !auto_en_i) begin
          w_cnt_next = '0;
        end else if (r_cnt == c_idle_last) begin
          w_state_next = SLEEP_REQ;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      SLEEP_REQ: begin
        // A wake racing the acknowledge always wins: the domain stays clocked.
        if (w_wake) begin
          w_state_next    = RUN;
          w_cnt_next      = '0;
          w_wake_ack_next = wake_req_i;
        end else if (sleep_ack_i) begin
          w_state_next = GATED;
        end
      end
      GATED: begin
        if (w_wake) begin
          w_state_next       = WAKE;
          w_cnt_next         = '0;
          w_wake_by_req_next = wake_req_i;
        end
      end
      WAKE: begin
        if (r_cnt == c_wake_last) begin
          w_state_next    = RUN;
          w_cnt_next      = '0;
          w_wake_ack_next = r_wake_by_req;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_wake_by_req <= 1'b0;
      clk_en_o      <= 1'b1;
      sleep_req_o   <= 1'b0;
      wake_ack_o    <= 1'b0;
      gated_o       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_wake_by_req <= w_wake_by_req_next;
      clk_en_o      <= (w_state_next != GATED);
      sleep_req_o   <= (w_state_next == SLEEP_REQ);
      wake_ack_o    <= w_wake_ack_next;
      gated_o       <= (w_state_next == GATED);
    end
  end

  assign state_o = r_state;

  tc_clk_gating #(
    .IS_FUNCTIONAL(1'b1)
  ) i_clkgate (
    .clk_i    (clk_i),
    .en_i     (clk_en_o),
    .test_en_i(test_en_i),
    .clk_o    (clk_o)
  );

endmodule
`default_nettype wire

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Idle-driven controller that produces the enable for a clock-gating cell and owns the gated clock it feeds. It runs on the free-running clock and counts idle cycles of a downstream domain. Once that domain acknowledges a sleep request, it closes the gate, and it reopens the gate on a wake request with a fixed settle delay before acknowledging. It sits between the SoC power/idle logic and a peripheral or core clock domain.

Parameters:
IdleCycles, 16, consecutive idle cycles in RUN before sleep is requested; must be >= 1
WakeCycles, 2, cycles the enable is held high in WAKE before wake_ack_o; must be >= 1
CntWidth, $clog2(max(IdleCycles,WakeCycles)+1), derived counter width; not to be overridden

Ports:
clk_i  in  1  free-running clock; all state is on its rising edge
rst_i  in  1  asynchronous, active-high reset
test_en_i  in  1  DFT bypass, forwarded to the gating cell SCE input
auto_en_i  in  1  1 = idle counting allowed; 0 = counter held at 0, never sleeps
busy_i  in  1  downstream domain busy (level)
wake_req_i  in  1  wake request (level)
sleep_ack_i  in  1  downstream accepts sleep
sleep_req_o  out  1  sleep request to downstream
wake_ack_o  out  1  one-cycle pulse: domain clock running and settled
clk_en_o  out  1  registered enable presented to the gating cell
gated_o  out  1  1 while in GATED
state_o  out  2  current state encoding
clk_o  out  1  gated clock

Behaviour:
- Reset values: state RUN, clk_en_o=1, sleep_req_o=0, wake_ack_o=0, gated_o=0, counter=0. Reset acts immediately without a clock edge, so the gate opens asynchronously. The cell's latch keeps this glitch-free.
- All outputs except clk_o are registered.
- Wake condition: wake = wake_req_i | busy_i.
- RUN (0):
  - If wake or !auto_en_i, counter clears.
  - Otherwise counter increments.
  - When an idle cycle occurs with counter == IdleCycles-1, go to SLEEP_REQ. sleep_req_o=1 from the next cycle.
  - wake_req_i in RUN produces a wake_ack_o pulse on the next cycle.
- SLEEP_REQ (1):
  - sleep_req_o is held at 1 until exit.
  - If wake is seen (including in the same cycle as sleep_ack_i), abort: go to RUN, sleep_req_o=0, counter=0. If wake_req_i caused the abort, pulse wake_ack_o next cycle.
  - Else if sleep_ack_i, go to GATED. clk_en_o=0 and sleep_req_o=0 from the next cycle.
- GATED (2):
  - clk_en_o=0, gated_o=1.
  - On wake, go to WAKE. clk_en_o=1 from the next cycle, counter=0.
  - sleep_ack_i is ignored.
- WAKE (3):
  - clk_en_o=1, counter increments.
  - At counter == WakeCycles-1, go to RUN and pulse wake_ack_o for one cycle. The pulse occurs only if wake_req_i caused the wake; a busy-only wake gives no pulse.
  - Inputs are ignored until RUN.
- clk_o is clk_i gated by clk_en_o through the cell.
  - test_en_i=1 forces clk_o to follow clk_i in every state.
  - test_en_i does not alter the FSM.
- The counter saturates; it never wraps.

Decomposition:
- Package clk_gate_ctrl_pkg holds the state enum clk_gate_state_e: RUN=2'd0, SLEEP_REQ=2'd1, GATED=2'd2, WAKE=2'd3.
- One sub-module: tc_clk_gating (IS_FUNCTIONAL=1) instance i_clkgate. It takes clk_i, clk_en_o and test_en_i and drives clk_o.
- No other hierarchy.

Test Plan (IdleCycles=4, WakeCycles=2):
1. Assert rst_i for 3 cycles, then release with auto_en_i=0 -> clk_en_o=1, state_o=0, sleep_req_o=0, clk_o toggles; no sleep after 100 idle cycles.
2. auto_en_i=1, busy_i=0 -> sleep_req_o rises after 4 idle cycles. Assert sleep_ack_i -> next cycle clk_en_o=0, gated_o=1, state_o=2, and clk_o is held low.
3. From GATED, pulse wake_req_i -> clk_en_o=1 next cycle, state_o=3, clk_o resumes. wake_ack_o pulses exactly 2 cycles later and state_o=0.
4. busy_i high for one cycle on idle cycle 3 -> counter resets. sleep_req_o rises only after 4 further idle cycles.
5. In SLEEP_REQ, assert wake_req_i and sleep_ack_i in the same cycle -> state_o=0, sleep_req_o=0, clk_en_o stays 1, one wake_ack_o pulse.
6. In GATED, set test_en_i=1 -> clk_o toggles while clk_en_o=0. Then assert rst_i mid-cycle -> clk_en_o=1 before the next clk_i edge and state_o=0.
